debouncer_multi: RTL and testbench
==================================

Name: debouncer_multi

Overview:
Per-channel synchroniser, debouncer and edge detector for button/switch banks. Debounces both press and release with an up/down saturating integrator and hysteresis. Emits one-cycle rise/fall pulses and optional auto-repeat pulses. All channels share one sample-tick divider. Sits between board pins and the user-IO / MMIO button registers.

Parameters:
WIDTH, 1, number of independent channels
SAMPLE_COUNT_MAX, 25000, clk cycles per sample tick (>=2)
PULSE_COUNT_MAX, 150, ticks of consistent input needed to change debounced level (>=1)
ACTIVE_LOW, 0, 1 = raw inputs idle high; inverted at input
REPEAT_EN, 0, 1 = enable repeat_pulse generation
REPEAT_DELAY, 500, ticks of held level before first repeat pulse (>=1)
REPEAT_PERIOD, 100, ticks between subsequent repeat pulses (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
glitchy_signal  in  WIDTH  raw asynchronous inputs
debounced_signal  out  WIDTH  debounced level, 1 = pressed
rising_pulse  out  WIDTH  one-cycle strobe on debounced 0->1
falling_pulse  out  WIDTH  one-cycle strobe on debounced 1->0
repeat_pulse  out  WIDTH  one-cycle auto-repeat strobe (0 when REPEAT_EN=0)
sample_tick  out  1  shared tick, for debug/verification

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset state: divider=0; sync flops=0 (normalised idle); integrators=0; repeat counters=0. All outputs 0.
- Normalise: n[i] = glitchy_signal[i] XOR ACTIVE_LOW. Pass n[i] through a 2-flop synchroniser to get s[i].
- Divider counts 0..SAMPLE_COUNT_MAX-1 and then wraps to 0. sample_tick is combinational and equals (divider == SAMPLE_COUNT_MAX-1). So there is one tick every SAMPLE_COUNT_MAX cycles, the first at cycle SAMPLE_COUNT_MAX-1 after reset release.
- Integrator cnt[i], width $clog2(PULSE_COUNT_MAX+1). Updates only on a tick:
  - s=1 and cnt<MAX: increment.
  - s=0 and cnt>0: decrement.
  - Otherwise hold (saturates at 0 and at MAX). No change between ticks.
- Level register lvl[i], with hysteresis:
  - Set to 1 on the tick where cnt goes MAX-1 -> MAX.
  - Cleared to 0 on the tick where cnt goes 1 -> 0.
  - Otherwise holds. Glitches shorter than the hysteresis window never toggle lvl.
- PULSE_COUNT_MAX=1: cnt toggles between 0 and 1; lvl follows s at tick rate.
- debounced_signal = lvl, registered.
- rising_pulse[i] / falling_pulse[i] are registered and high for exactly one cycle. They assert in the same cycle lvl first reads 1 (rise) or first reads 0 (fall). They can never assert together on one channel.
- Repeat (REPEAT_EN=1), per channel:
  - rc[i] clears to 0 whenever lvl=0 or a rising_pulse fires.
  - While lvl=1, rc[i] increments on each tick.
  - The first repeat pulse fires on the tick where rc reaches REPEAT_DELAY. rc then reloads to REPEAT_DELAY-REPEAT_PERIOD, so pulses recur every REPEAT_PERIOD ticks.
  - repeat_pulse is registered, one cycle wide, and never coincides with rising_pulse.
- Latency: steady raw change to lvl change is 2 cycles plus PULSE_COUNT_MAX ticks. That is at most 2 + SAMPLE_COUNT_MAX*PULSE_COUNT_MAX cycles, not counting partial integrator state.
- Channels are fully independent; only the divider is shared.
- rst asserted mid-count: all state clears next edge. No pulses are emitted on reset, even if lvl was 1.
- Widths: every comparison is against parameters at the full counter width, with no truncation. The repeat counter is $clog2(REPEAT_DELAY+1) wide.

Test Plan:
- Params WIDTH=2, SAMPLE=4, PULSE=3. Hold ch0 raw=1 from reset:
  - ticks at cycles 3, 7 and 11; lvl[0]=1 and rising_pulse[0] one cycle at cycle 12, ±sync offset checked exactly.
  - ch1 stays 0 throughout.
- Press to saturation, then drop raw to 0 for 1 tick and back to 1:
  - cnt goes 3 -> 2 -> 3; lvl stays 1; no falling or rising pulse.
- Release after saturation, raw=0 held:
  - lvl=0 after exactly 3 ticks; falling_pulse one cycle; cnt=0.
- Raw toggling every cycle for 50 cycles:
  - lvl never changes; no pulses on any output.
- ACTIVE_LOW=1, raw idles 1 and is driven 0 for a press:
  - identical timing to scenario 1 with inverted stimulus.
  - debounced_signal=0 during idle.
- REPEAT_EN=1, DELAY=4, PERIOD=2, hold pressed:
  - repeat_pulse on ticks 4, 6, 8 after the rise.
  - assert rst mid-hold: all outputs 0 next cycle and no falling_pulse.

Source files
------------

// File: rtl/debouncer_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : debouncer_multi                                              |
// | Description : Multi-channel synchroniser + integrating debouncer with      |
// |               hysteresis, rise/fall strobes and optional auto-repeat.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

module debouncer_multi #(
    parameter int WIDTH            = 1,
    parameter int SAMPLE_COUNT_MAX = 25000,
    parameter int PULSE_COUNT_MAX  = 150,
    parameter int ACTIVE_LOW       = 0,
    parameter int REPEAT_EN        = 0,
    parameter int REPEAT_DELAY     = 500,
    parameter int REPEAT_PERIOD    = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] glitchy_signal,
    output logic [WIDTH-1:0] debounced_signal,
    output logic [WIDTH-1:0] rising_pulse,
    output logic [WIDTH-1:0] falling_pulse,
    output logic [WIDTH-1:0] repeat_pulse,
    output logic             sample_tick
);

    localparam int c_div_w = (SAMPLE_COUNT_MAX > 1) ? $clog2(SAMPLE_COUNT_MAX) : 1;
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(SAMPLE_COUNT_MAX - 1);

    localparam int c_cnt_w = $clog2(PULSE_COUNT_MAX + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_top = c_cnt_w'(PULSE_COUNT_MAX);
    localparam logic [c_cnt_w-1:0] c_cnt_pre = c_cnt_w'(PULSE_COUNT_MAX - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    localparam logic c_inv = (ACTIVE_LOW != 0);

    logic [c_div_w-1:0] r_div;
    logic               w_tick;
    logic [WIDTH-1:0]   w_norm;
    logic [WIDTH-1:0]   r_sync_meta;
    logic [WIDTH-1:0]   r_sync;

    // Shared sample-tick divider
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= '0;
        end else if (r_div == c_div_last) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    assign w_tick      = (r_div == c_div_last);
    assign sample_tick = w_tick;

    // Inputs are normalised to "1 = pressed" before synchronising, so the
    // synchroniser reset value of 0 always means idle.
    assign w_norm = glitchy_signal ^ {WIDTH{c_inv}};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_meta <= '0;
            r_sync      <= '0;
        end else begin
            r_sync_meta <= w_norm;
            r_sync      <= r_sync_meta;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic [c_cnt_w-1:0] r_cnt;
        logic               r_lvl;
        logic               r_rise;
        logic               r_fall;
        logic               w_s;
        logic               w_set;
        logic               w_clr;

        assign w_s   = r_sync[i];
        assign w_set = w_tick && w_s && (r_cnt == c_cnt_pre) && !r_lvl;
        assign w_clr = w_tick && !w_s && (r_cnt == c_cnt_one) && r_lvl;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= '0;
            end else if (w_tick) begin
                if (w_s && (r_cnt < c_cnt_top)) begin
                    r_cnt <= r_cnt + 1'b1;
                end else if (!w_s && (r_cnt != '0)) begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end

        // Level only moves at the integrator extremes, giving the hysteresis.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_lvl  <= 1'b0;
                r_rise <= 1'b0;
                r_fall <= 1'b0;
            end else begin
                r_rise <= w_set;
                r_fall <= w_clr;
                if (w_set) begin
                    r_lvl <= 1'b1;
                end else if (w_clr) begin
                    r_lvl <= 1'b0;
                end
            end
        end

        assign debounced_signal[i] = r_lvl;
        assign rising_pulse[i]     = r_rise;
        assign falling_pulse[i]    = r_fall;

        if (REPEAT_EN != 0) begin : g_repeat
            localparam int c_rc_w = $clog2(REPEAT_DELAY + 1);
            localparam logic [c_rc_w-1:0] c_rc_last = c_rc_w'(REPEAT_DELAY - 1);
            localparam logic [c_rc_w-1:0] c_rc_reload =
                (REPEAT_PERIOD >= REPEAT_DELAY) ? '0 : c_rc_w'(REPEAT_DELAY - REPEAT_PERIOD);

            logic [c_rc_w-1:0] r_rc;
            logic              r_rep;
            logic              w_hit;

            // No auto-repeat on the tick that releases the channel.
            assign w_hit = w_tick && r_lvl && !w_clr && (r_rc == c_rc_last);

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rc  <= '0;
                    r_rep <= 1'b0;
                end else begin
                    r_rep <= w_hit;
                    if (!r_lvl || r_rise) begin
                        r_rc <= '0;
                    end else if (w_hit) begin
                        r_rc <= c_rc_reload;
                    end else if (w_tick) begin
                        r_rc <= r_rc + 1'b1;
                    end
                end
            end

            assign repeat_pulse[i] = r_rep;
        end else begin : g_no_repeat
            assign repeat_pulse[i] = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_debouncer_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_debouncer_multi                                           |
// | Description : Directed, table-driven bench for debouncer_multi.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

module tb_debouncer_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [1:0] raw_a, raw_b;
    logic       raw_c;
    logic [1:0] deb_a, rise_a, fall_a, rep_a;
    logic [1:0] deb_b, rise_b, fall_b, rep_b;
    logic       deb_c, rise_c, fall_c, rep_c;
    logic       tick_a, tick_b, tick_c;

    debouncer_multi #(
        .WIDTH(2), .SAMPLE_COUNT_MAX(4), .PULSE_COUNT_MAX(3), .ACTIVE_LOW(0),
        .REPEAT_EN(1), .REPEAT_DELAY(4), .REPEAT_PERIOD(2)
    ) dut_a (
        .clk(clk), .rst(rst), .glitchy_signal(raw_a), .debounced_signal(deb_a),
        .rising_pulse(rise_a), .falling_pulse(fall_a), .repeat_pulse(rep_a),
        .sample_tick(tick_a)
    );

    debouncer_multi #(
        .WIDTH(2), .SAMPLE_COUNT_MAX(4), .PULSE_COUNT_MAX(3), .ACTIVE_LOW(1),
        .REPEAT_EN(0), .REPEAT_DELAY(4), .REPEAT_PERIOD(2)
    ) dut_b (
        .clk(clk), .rst(rst), .glitchy_signal(raw_b), .debounced_signal(deb_b),
        .rising_pulse(rise_b), .falling_pulse(fall_b), .repeat_pulse(rep_b),
        .sample_tick(tick_b)
    );

    debouncer_multi #(
        .WIDTH(1), .SAMPLE_COUNT_MAX(2), .PULSE_COUNT_MAX(1), .ACTIVE_LOW(0),
        .REPEAT_EN(0), .REPEAT_DELAY(4), .REPEAT_PERIOD(2)
    ) dut_c (
        .clk(clk), .rst(rst), .glitchy_signal(raw_c), .debounced_signal(deb_c),
        .rising_pulse(rise_c), .falling_pulse(fall_c), .repeat_pulse(rep_c),
        .sample_tick(tick_c)
    );

    typedef struct {
        int         ncyc;
        logic [1:0] raw;    // dut_a polarity; dut_b is driven with the complement
        logic       deb0;
        int         rise0;
        int         fall0;
        int         rep0;
    } seg_t;

    seg_t segs[5];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_rise_a[2], n_fall_a[2], n_rep_a[2];
    int n_rise_b[2], n_fall_b[2], n_rep_b[2];
    int n_rise_c, n_fall_c, n_rep_c;
    int n_deb_hi;
    int waited;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_counts();
        for (int ch = 0; ch < 2; ch++) begin
            n_rise_a[ch] = 0; n_fall_a[ch] = 0; n_rep_a[ch] = 0;
            n_rise_b[ch] = 0; n_fall_b[ch] = 0; n_rep_b[ch] = 0;
        end
        n_rise_c = 0; n_fall_c = 0; n_rep_c = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        for (int ch = 0; ch < 2; ch++) begin
            n_rise_a[ch] += int'(rise_a[ch]);
            n_fall_a[ch] += int'(fall_a[ch]);
            n_rep_a[ch]  += int'(rep_a[ch]);
            n_rise_b[ch] += int'(rise_b[ch]);
            n_fall_b[ch] += int'(fall_b[ch]);
            n_rep_b[ch]  += int'(rep_b[ch]);
        end
        n_rise_c += int'(rise_c);
        n_fall_c += int'(fall_c);
        n_rep_c  += int'(rep_c);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " deb_a"}, deb_a, 0);
        check({tag, " rise_a"}, rise_a, 0);
        check({tag, " fall_a"}, fall_a, 0);
        check({tag, " rep_a"}, rep_a, 0);
        check({tag, " tick_a"}, tick_a, 0);
        check({tag, " deb_b"}, deb_b, 0);
        check({tag, " fall_b"}, fall_b, 0);
        check({tag, " deb_c"}, deb_c, 0);
        check({tag, " fall_c"}, fall_c, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got 0, want 1");
        $fatal(1, "watchdog expired");
    end

    initial begin
        segs[0] = '{4,  2'b00, 1'b1, 0, 0, 0};  // one-tick glitch low: cnt 3->2->3
        segs[1] = '{12, 2'b01, 1'b1, 0, 0, 2};
        segs[2] = '{10, 2'b00, 1'b1, 0, 0, 1};  // release: two ticks not enough
        segs[3] = '{1,  2'b00, 1'b0, 0, 1, 0};  // third tick clears the level
        segs[4] = '{4,  2'b00, 1'b0, 0, 0, 0};

        // Reset with channel 0 already pressed on every DUT
        rst   = 1'b1;
        raw_a = 2'b01;
        raw_b = 2'b10;
        raw_c = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        check("reset rep_c", rep_c, 0);
        rst = 1'b0;
        cyc = 0;
        clear_counts();

        // Press from reset, then hold through the auto-repeat window
        for (int k = 1; k <= 45; k++) begin
            step();
            check($sformatf("p1 k=%0d deb_a", k), deb_a, {1'b0, k >= 12});
            check($sformatf("p1 k=%0d rise_a", k), rise_a, {1'b0, k == 12});
            check($sformatf("p1 k=%0d fall_a", k), fall_a, 0);
            check($sformatf("p1 k=%0d rep_a", k), rep_a, {1'b0, (k == 28) || (k == 36) || (k == 44)});
            check($sformatf("p1 k=%0d tick_a", k), tick_a, (k % 4) == 3);
            check($sformatf("p1 k=%0d deb_b", k), deb_b, {1'b0, k >= 12});
            check($sformatf("p1 k=%0d rise_b", k), rise_b, {1'b0, k == 12});
            check($sformatf("p1 k=%0d rep_b", k), rep_b, 0);
            check($sformatf("p1 k=%0d tick_b", k), tick_b, (k % 4) == 3);
            check($sformatf("p1 k=%0d deb_c", k), deb_c, k >= 4);
            check($sformatf("p1 k=%0d rise_c", k), rise_c, k == 4);
            check($sformatf("p1 k=%0d tick_c", k), tick_c, (k % 2) == 1);
        end

        // Glitch, re-press, and release segments
        raw_c = 1'b0;
        clear_counts();
        for (int s = 0; s < 5; s++) begin
            clear_counts();
            raw_a = segs[s].raw;
            raw_b = ~segs[s].raw;
            for (int n = 0; n < segs[s].ncyc; n++) step();
            check($sformatf("seg%0d deb_a0", s), deb_a[0], segs[s].deb0);
            check($sformatf("seg%0d deb_a1", s), deb_a[1], 0);
            check($sformatf("seg%0d rise_a0", s), n_rise_a[0], segs[s].rise0);
            check($sformatf("seg%0d fall_a0", s), n_fall_a[0], segs[s].fall0);
            check($sformatf("seg%0d rep_a0", s), n_rep_a[0], segs[s].rep0);
            check($sformatf("seg%0d ch1_a pulses", s), n_rise_a[1] + n_fall_a[1] + n_rep_a[1], 0);
            check($sformatf("seg%0d deb_b0", s), deb_b[0], segs[s].deb0);
            check($sformatf("seg%0d deb_b1", s), deb_b[1], 0);
            check($sformatf("seg%0d rise_b0", s), n_rise_b[0], segs[s].rise0);
            check($sformatf("seg%0d fall_b0", s), n_fall_b[0], segs[s].fall0);
            check($sformatf("seg%0d rep_b0", s), n_rep_b[0], 0);
            check($sformatf("seg%0d ch1_b pulses", s), n_rise_b[1] + n_fall_b[1] + n_rep_b[1], 0);
            if (s == 0) begin
                check("seg0 fall_c", n_fall_c, 1);
                check("seg0 deb_c", deb_c, 0);
            end
        end

        // Raw toggling every cycle; phase chosen so every tick samples idle
        clear_counts();
        n_deb_hi = 0;
        for (int n = 0; n < 50; n++) begin
            raw_a = (cyc % 2 == 0) ? 2'b11 : 2'b00;
            raw_b = ~raw_a;
            raw_c = raw_a[0];
            step();
            n_deb_hi += int'(deb_a != 0) + int'(deb_b != 0) + int'(deb_c != 0);
        end
        raw_a = 2'b00;
        raw_b = 2'b11;
        raw_c = 1'b0;
        check("toggle deb high cycles", n_deb_hi, 0);
        check("toggle pulses a", n_rise_a[0] + n_rise_a[1] + n_fall_a[0] + n_fall_a[1] + n_rep_a[0] + n_rep_a[1], 0);
        check("toggle pulses b", n_rise_b[0] + n_rise_b[1] + n_fall_b[0] + n_fall_b[1], 0);
        check("toggle pulses c", n_rise_c + n_fall_c, 0);

        // Press, hold into repeat, then reset mid-hold
        raw_a = 2'b01;
        raw_b = 2'b10;
        raw_c = 1'b1;
        waited = 0;
        while (deb_a[0] !== 1'b1 && waited < 40) begin
            step();
            waited++;
        end
        check("hold reaches level", deb_a[0], 1);
        repeat (20) step();
        check("hold deb_b", deb_b, 2'b01);
        rst = 1'b1;
        step();
        check_all_zero("midrst");
        rst = 1'b0;
        cyc = 0;
        clear_counts();
        repeat (11) step();
        check("post-rst deb_a before 12", deb_a, 0);
        step();
        check("post-rst deb_a at 12", deb_a, 2'b01);
        check("post-rst rise_a at 12", rise_a, 2'b01);
        check("post-rst deb_b at 12", deb_b, 2'b01);
        check("post-rst deb_c", deb_c, 1);
        check("post-rst falls", n_fall_a[0] + n_fall_a[1] + n_fall_b[0] + n_fall_b[1] + n_fall_c, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
